// File: rtl/pix_clk_seq_pkg.sv
// Shared types and constants for the pixel-clock sequencer.
package pix_clk_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    SETTLE,
    RUN,
    LOST
  } pix_clk_state_e;

  localparam int unsigned ACC_W_DEF = 16;

  // Phase steps for a 48 MHz clk with a 16-bit accumulator (25.175 MHz, 40 MHz)
  localparam logic [ACC_W_DEF-1:0] STEP_640x480 = 16'h8644;
  localparam logic [ACC_W_DEF-1:0] STEP_800x600 = 16'hD555;

  // Width of the shared state timer: enough to hold the largest terminal count minus one
  function automatic int unsigned tmr_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pix_clk_seq_if.sv
// PLL / pixel-pipeline side signals of the pixel-clock sequencer.
interface pix_clk_seq_if #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 8
);
  logic             pll_lock;
  logic [ACC_W-1:0] step;
  logic             pll_resetb;
  logic             pix_rst;
  logic             pix_ce;
  logic             locked;
  logic [CNT_W-1:0] relock_cnt;
  logic             lock_lost;

  // Sequencer side
  modport master (
    input  pll_lock, step,
    output pll_resetb, pix_rst, pix_ce, locked, relock_cnt, lock_lost
  );

  // PLL wrapper / timing generator side
  modport slave (
    output pll_lock, step,
    input  pll_resetb, pix_rst, pix_ce, locked, relock_cnt, lock_lost
  );
endinterface

// File: rtl/pix_clk_seq_pix_ce_gen.sv
// Fractional pixel clock-enable: phase accumulator whose carry-out is the enable.
module pix_ce_gen #(
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [ACC_W-1:0] step_i,
  output logic             pix_ce_o
);

  logic [ACC_W-1:0] acc_q;
  logic             pix_ce_q;
  logic [ACC_W:0]   sum_c;

  assign sum_c = {1'b0, acc_q} + {1'b0, step_i};

  // Accumulate while enabled; hold cleared otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      pix_ce_q <= 1'b0;
    end else if (en_i) begin
      {pix_ce_q, acc_q} <= sum_c;
    end else begin
      acc_q    <= '0;
      pix_ce_q <= 1'b0;
    end
  end

  assign pix_ce_o = pix_ce_q;

endmodule

// File: rtl/pix_clk_seq.sv
// Pixel-clock sequencer: PLL reset/retry, lock qualification, pipeline reset and pixel enable.
// Optional relock statistics built when PIX_CLK_STATS_EN is defined.
module pix_clk_seq
  import pix_clk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SETTLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned ACC_W          = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic          clk,
  input  logic          rst,
  pix_clk_seq_if.master bus_if
);

  localparam int unsigned TMR_W = tmr_width(TIMEOUT_CYCLES, SETTLE_CYCLES, PLL_RST_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  pix_clk_state_e         state_q, state_d;
  logic [TMR_W-1:0]       cnt_q, cnt_d;
  logic                   pll_resetb_q, pix_rst_q, locked_q;
  logic                   run_en_c;

  // Bring raw PLL lock into the clk domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], bus_if.pll_lock};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Next state; one timer shared by PLL_RST, WAIT_LOCK and SETTLE, cleared on every transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + TMR_W'(1);
    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == TMR_W'(PLL_RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        // Lock loss takes priority over a completing settle count
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == TMR_W'(SETTLE_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) state_d = LOST;
      end
      LOST: begin
        cnt_d   = '0;
        state_d = PLL_RST;
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; outputs registered off the next state so they line up with the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      pll_resetb_q <= 1'b0;
      pix_rst_q    <= 1'b1;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pll_resetb_q <= (state_d != PLL_RST);
      pix_rst_q    <= (state_d != RUN);
      locked_q     <= (state_d == RUN);
    end
  end

  assign bus_if.pll_resetb = pll_resetb_q;
  assign bus_if.pix_rst    = pix_rst_q;
  assign bus_if.locked     = locked_q;

  // Enable tracks the next state so pix_ce can only be high while in RUN
  assign run_en_c = (state_d == RUN);

  pix_ce_gen #(
    .ACC_W (ACC_W)
  ) u_pix_ce_gen (
    .clk      (clk),
    .rst      (rst),
    .en_i     (run_en_c),
    .step_i   (bus_if.step),
    .pix_ce_o (bus_if.pix_ce)
  );

`ifdef PIX_CLK_STATS_EN
  logic [CNT_W-1:0] relock_q;
  logic             lost_q;
  logic             lost_evt_c;
  logic             retry_evt_c;

  assign lost_evt_c  = (state_q == RUN) && (state_d == LOST);
  assign retry_evt_c = lost_evt_c || ((state_q == WAIT_LOCK) && (state_d == PLL_RST));

  // Saturating retry/loss counter and sticky loss flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      relock_q <= '0;
      lost_q   <= 1'b0;
    end else begin
      if (retry_evt_c && (relock_q != '1)) relock_q <= relock_q + CNT_W'(1);
      if (lost_evt_c) lost_q <= 1'b1;
    end
  end

  assign bus_if.relock_cnt = relock_q;
  assign bus_if.lock_lost  = lost_q;
`else
  assign bus_if.relock_cnt = CNT_W'(0);
  assign bus_if.lock_lost  = 1'b0;
`endif

endmodule

// File: tb/tb_pix_clk_seq.sv
// Directed bench for pix_clk_seq (SETTLE=8, PLL_RST=4, TIMEOUT=32, SYNC=2).
// Statistics expectations follow PIX_CLK_STATS_EN.
module tb_pix_clk_seq;

`ifdef PIX_CLK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pix_clk_seq_if #(.ACC_W(16), .CNT_W(8)) bus_if ();

  pix_clk_seq #(
    .SYNC_STAGES    (2),
    .SETTLE_CYCLES  (8),
    .TIMEOUT_CYCLES (32),
    .PLL_RST_CYCLES (4),
    .ACC_W          (16),
    .CNT_W          (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    logic exp_rb;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.pll_lock = 1'b0;
    bus_if.step     = 16'h8000;
    #3 rst = 1'b0;

    // Reset values
    repeat (3) tick();
    check_eq("rst_pll_resetb", 32'(bus_if.pll_resetb), 32'd0);
    check_eq("rst_pix_rst",    32'(bus_if.pix_rst),    32'd1);
    check_eq("rst_pix_ce",     32'(bus_if.pix_ce),     32'd0);
    check_eq("rst_locked",     32'(bus_if.locked),     32'd0);
    check_eq("rst_relock_cnt", 32'(bus_if.relock_cnt), 32'd0);
    check_eq("rst_lock_lost",  32'(bus_if.lock_lost),  32'd0);

    // No lock: 4 low cycles, then every 36 cycles (32 wait + 4 reset) another 4 low
    rst = 1'b1;
    for (int k = 1; k <= 112; k++) begin
      tick();
      exp_rb = !((k < 4) || ((k >= 36) && (((k - 36) % 36) < 4)));
      check_eq($sformatf("timeout_pll_resetb_c%0d", k), 32'(bus_if.pll_resetb), 32'(exp_rb));
    end
    check_eq("timeout_locked",     32'(bus_if.locked),     32'd0);
    check_eq("timeout_pix_rst",    32'(bus_if.pix_rst),    32'd1);
    check_eq("timeout_relock_cnt", 32'(bus_if.relock_cnt), STATS ? 32'd3 : 32'd0);

    // Lock present from release: WAIT at 4, SETTLE 5..12, RUN at 13
    rst = 1'b0;
    tick();
    check_eq("rerst_relock_cnt", 32'(bus_if.relock_cnt), 32'd0);
    bus_if.pll_lock = 1'b1;
    rst = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 3)  check_eq("up_pll_resetb_c3", 32'(bus_if.pll_resetb), 32'd0);
      if (k == 4)  check_eq("up_pll_resetb_c4", 32'(bus_if.pll_resetb), 32'd1);
      if (k == 12) begin
        check_eq("up_locked_c12",  32'(bus_if.locked),  32'd0);
        check_eq("up_pix_rst_c12", 32'(bus_if.pix_rst), 32'd1);
      end
    end
    check_eq("up_locked_c13",  32'(bus_if.locked),  32'd1);
    check_eq("up_pix_rst_c13", 32'(bus_if.pix_rst), 32'd0);
    check_eq("up_pix_ce_c13",  32'(bus_if.pix_ce),  32'd0);

    // step 0x8000: pulse on every second cycle starting at cycle 14
    for (int i = 0; i < 16; i++) begin
      tick();
      check_eq($sformatf("half_rate_i%0d", i), 32'(bus_if.pix_ce), 32'((i % 2) == 0));
    end

    // step 0x5555 mid-run: 65536 adds give exactly 21845 carries
    bus_if.step = 16'h5555;
    pulses = 0;
    for (int i = 0; i < 65536; i++) begin
      tick();
      if (bus_if.pix_ce) pulses++;
    end
    check_eq("third_rate_pulses", 32'(pulses), 32'd21845);
    check_eq("third_rate_locked", 32'(bus_if.locked), 32'd1);

    // One-cycle lock drop at t: lock_s low at t+2, LOST at t+3, PLL_RST at t+4
    bus_if.pll_lock = 1'b0;
    tick();                                   // t+1
    bus_if.pll_lock = 1'b1;
    tick();                                   // t+2
    check_eq("drop_locked_t2", 32'(bus_if.locked), 32'd1);
    tick();                                   // t+3
    check_eq("drop_locked_t3",  32'(bus_if.locked),  32'd0);
    check_eq("drop_pix_rst_t3", 32'(bus_if.pix_rst), 32'd1);
    check_eq("drop_pix_ce_t3",  32'(bus_if.pix_ce),  32'd0);
    tick();                                   // t+4
    check_eq("drop_pll_resetb_t4", 32'(bus_if.pll_resetb), 32'd0);
    check_eq("drop_lock_lost_t4",  32'(bus_if.lock_lost),  32'(STATS));
    repeat (4) tick();                        // t+8
    check_eq("drop_pll_resetb_t8", 32'(bus_if.pll_resetb), 32'd1);
    repeat (3) tick();                        // t+11, SETTLE since t+9

    // Glitch mid-SETTLE: lock_s low at t+13, WAIT at t+14, SETTLE restarts t+15, RUN at t+23
    bus_if.pll_lock = 1'b0;
    tick();                                   // t+12
    bus_if.pll_lock = 1'b1;
    tick();                                   // t+13
    tick();                                   // t+14
    check_eq("glitch_locked_t14", 32'(bus_if.locked), 32'd0);
    repeat (8) tick();                        // t+22
    check_eq("glitch_locked_t22",  32'(bus_if.locked),  32'd0);
    check_eq("glitch_pix_rst_t22", 32'(bus_if.pix_rst), 32'd1);
    tick();                                   // t+23
    check_eq("glitch_locked_t23",     32'(bus_if.locked),     32'd1);
    check_eq("glitch_pix_rst_t23",    32'(bus_if.pix_rst),    32'd0);
    check_eq("glitch_relock_cnt",     32'(bus_if.relock_cnt), STATS ? 32'd1 : 32'd0);
    check_eq("relock_lock_lost_kept", 32'(bus_if.lock_lost),  32'(STATS));

    // Asynchronous reset in RUN with a near-continuous enable
    bus_if.step = 16'hFFFF;
    repeat (3) tick();
    check_eq("pre_arst_pix_ce", 32'(bus_if.pix_ce), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_pix_rst",    32'(bus_if.pix_rst),    32'd1);
    check_eq("arst_locked",     32'(bus_if.locked),     32'd0);
    check_eq("arst_pix_ce",     32'(bus_if.pix_ce),     32'd0);
    check_eq("arst_pll_resetb", 32'(bus_if.pll_resetb), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
